uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
//  Transmit-side counterpart of the receive byte store: a DEPTH-entry circular byte
//  queue feeding an 8N1 UART serializer that drives the tx line.
//  Host logic pushes bytes; the block drains them oldest-first, back-to-back, LSB first.
//  Sits between the board-side byte source (switches/control FSM) and the FPGA tx pin.
// PARAMETERS
//  CLKS_PER_BIT  10416  clk cycles per bit (100 MHz / 9600 baud); must be >= 2
//  DEPTH         4      queue entries; power of two, >= 2
// PORTS
//  clk       in   1                     system clock, all state on rising edge
//  clr_n     in   1                     async active-low reset
//  wr_en     in   1                     push request, one byte per asserted cycle
//  wr_data   in   8                     byte to push, sampled when wr_en=1
//  full      out  1                     queue holds DEPTH bytes (registered)
//  empty     out  1                     queue holds 0 bytes (registered)
//  count     out  $clog2(DEPTH)+1       bytes currently queued, excludes byte in flight
//  busy      out  1                     serializer not in IDLE
//  tx        out  1                     serial line, idle high
// BEHAVIOUR
//  Reset (clr_n=0, async): tx=1, busy=0, empty=1, full=0, count=0, rd/wr ptrs=0, FSM=IDLE,
//   baud counter=0, bit index=0. Reset mid-frame aborts frame; tx high at once; queue discarded.
//  Push: accepted iff wr_en=1 and full=0 at the edge; else byte dropped, no state change.
//   Accept decision uses registered full only; a same-cycle pop never admits a push into full.
//  Pointers: wrap modulo DEPTH; count = pushes - pops; full=(count==DEPTH), empty=(count==0).
//  Simultaneous accepted push and pop: count unchanged, both pointers advance.
//  FSM states: IDLE, START, DATA, STOP [, PARITY with option].
//   IDLE: tx=1. If empty=0: pop head into shift reg, bit index=0, go START. Pop edge = E1.
//   START: tx=0 for CLKS_PER_BIT cycles, then DATA.
//   DATA: tx=shift[0], each bit CLKS_PER_BIT cycles; shift right; after bit 7 go STOP
//    (or PARITY when enabled).
//   STOP: tx=1 for CLKS_PER_BIT cycles. On last STOP cycle: if empty=0 pop and go START
//    directly (no idle gap between frames); else go IDLE.
//  Latency: push at edge E0 on empty queue and idle FSM -> empty=0 after E0; pop at E1;
//   tx falls after E1. Frame = 10 x CLKS_PER_BIT cycles (11 x with parity).
//  busy=1 from pop edge until return to IDLE. tx is a registered output (glitch-free).
//  Baud counter counts 0..CLKS_PER_BIT-1, reloads to 0 on every state/bit change.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state after DATA, tx = ^byte (even parity) for one bit
//   time; frame 8E1, 11 bit times. Undefined: no PARITY state, frame 8N1, 10 bit times.
//  All other behaviour identical in both builds.
// TESTING  (CLKS_PER_BIT=4, DEPTH=4)
//  1 Reset: clr_n=0 mid-frame -> tx=1, busy=0, empty=1, count=0 same cycle, no further bits.
//  2 Single byte: push 0xA5 when idle -> tx low after E1 for 4 clks, then bits 1,0,1,0,0,1,0,1
//    4 clks each, stop high 4 clks, busy=0 after 40 clks from E1.
//  3 Back-to-back: push 0x01,0x02,0x03 consecutive cycles -> three frames with stop bit
//    immediately followed by start bit, total 120 clks busy, order 01,02,03.
//  4 Overflow: while frame 0x11 in flight push 0x22,0x33,0x44,0x55,0x66 -> full=1 after 4th,
//    0x66 dropped, count=4; transmitted order 11,22,33,44,55.
//  5 Push+pop same edge with count=4 at end of stop bit -> push dropped, count=3; with count=2
//    -> push accepted, count stays 2.
//  6 UART_TX_PARITY_EN: push 0x07 -> parity bit 1 after bit 7, 44 clks frame; 0x03 -> parity 0.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Circular byte queue draining into an 8N1 UART serializer (LSB first).
// Define UART_TX_PARITY_EN for an even-parity bit (8E1 frames).
module uart_tx_queue #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_e;
`endif

  state_e        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;

  logic          bit_end;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  always_comb begin
    bit_end = (baud_q == BAUD_LAST);
    push    = wr_en && !full_q;
    pop     = !empty_q &&
              ((state_q == S_IDLE) ||
               ((state_q == S_STOP) && bit_end));
    head    = mem[rd_q];
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= wr_data;
  end

  // Accept uses registered full only: a pop on the same edge never frees room.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= head;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^head;
`endif
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            // Chain straight into the next start bit when bytes are waiting.
            if (pop) begin
              shift_q <= head;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^head;
`endif
              bit_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;
  assign busy  = busy_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue at CLKS_PER_BIT=4, DEPTH=4.
// Build with UART_TX_PARITY_EN defined to cover the 8E1 frame.
module tb_uart_tx_queue;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int CPB = 4;

  logic       clk;
  logic       clr_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       busy;
  logic       tx;

  int total;
  int passed;

  uart_tx_queue #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .busy    (busy),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  // Entered at a negedge at offset off0 within a frame (offset 0 = first
  // negedge after the pop edge); returns at offset NB*CPB.
  task automatic check_frame(input logic [7:0] b, input int off0,
                             input logic p_last, input logic [7:0] pd);
    logic [NB-1:0] bits;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, b, 1'b0};
`endif
    for (int off = off0; off < NB*CPB; off++) begin
      if (off % CPB == 2) begin
        total++;
        if (tx !== bits[off/CPB])
          $display("FAIL frame_%h_bit%0d: tx=%b expected %b",
                   b, off/CPB, tx, bits[off/CPB]);
        else passed++;
      end
      if (off == NB*CPB-1) begin
        total++;
        if (busy !== 1'b1)
          $display("FAIL frame_%h_busy_end: busy=%b expected 1", b, busy);
        else passed++;
        if (p_last) begin
          wr_en   = 1'b1;
          wr_data = pd;
        end
      end
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({tx, busy, empty, full, count} !== 7'b1010000)
      $display("FAIL reset_state: tx/busy/empty/full/count=%b expected 1010000",
               {tx, busy, empty, full, count});
    else passed++;
    clr_n = 1'b1;
    @(negedge clk);
    // push a byte plus two queued ones, then reset mid-frame
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk); wr_data = 8'h66;
    @(negedge clk); wr_data = 8'h77;
    @(negedge clk); wr_en = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (busy !== 1'b1 || count !== 3'd2)
      $display("FAIL reset_pre: busy=%b count=%0d expected 1 2", busy, count);
    else passed++;
    clr_n = 1'b0;
    #1;
    total++;
    if ({tx, busy, empty, full, count} !== 7'b1010000)
      $display("FAIL reset_async: tx/busy/empty/full/count=%b expected 1010000",
               {tx, busy, empty, full, count});
    else passed++;
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) begin
        total++;
        $display("FAIL reset_quiet: cycle %0d tx=%b busy=%b expected 1 0",
                 i, tx, busy);
      end
    end
    total++;
    if (empty !== 1'b1 || count !== 3'd0)
      $display("FAIL reset_discard: empty=%b count=%0d expected 1 0",
               empty, count);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    total++;
    if ({tx, busy, empty, count} !== 6'b100001)
      $display("FAIL single_after_push: tx/busy/empty/count=%b expected 100001",
               {tx, busy, empty, count});
    else passed++;
    @(negedge clk);
    total++;
    if ({tx, busy, empty, count} !== 6'b011000)
      $display("FAIL single_after_pop: tx/busy/empty/count=%b expected 011000",
               {tx, busy, empty, count});
    else passed++;
    check_frame(8'hA5, 0, 1'b0, 8'h00);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL single_idle: busy=%b tx=%b expected 0 1", busy, tx);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_en = 1'b1; wr_data = 8'h01;
    @(negedge clk); wr_data = 8'h02;
    @(negedge clk); wr_data = 8'h03;
    total++;
    if (tx !== 1'b0 || count !== 3'd1)
      $display("FAIL b2b_first_start: tx=%b count=%0d expected 0 1", tx, count);
    else passed++;
    check_frame(8'h01, 0, 1'b0, 8'h00);
    check_frame(8'h02, 0, 1'b0, 8'h00);
    check_frame(8'h03, 0, 1'b0, 8'h00);
    total++;
    if (busy !== 1'b0 || empty !== 1'b1)
      $display("FAIL b2b_done: busy=%b empty=%b expected 0 1", busy, empty);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] vals [5];
    vals[0] = 8'h22; vals[1] = 8'h33; vals[2] = 8'h44;
    vals[3] = 8'h55; vals[4] = 8'h66;
    do_reset();
    wr_en = 1'b1; wr_data = 8'h11;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = vals[i];
      if (i == 4) begin
        total++;
        if (full !== 1'b1 || count !== 3'd4)
          $display("FAIL ovf_full: full=%b count=%0d expected 1 4", full, count);
        else passed++;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    total++;
    if (full !== 1'b1 || count !== 3'd4)
      $display("FAIL ovf_drop: full=%b count=%0d expected 1 4", full, count);
    else passed++;
    @(negedge clk);
    check_frame(8'h11, 6, 1'b0, 8'h00);
    check_frame(8'h22, 0, 1'b0, 8'h00);
    check_frame(8'h33, 0, 1'b0, 8'h00);
    check_frame(8'h44, 0, 1'b0, 8'h00);
    check_frame(8'h55, 0, 1'b0, 8'h00);
    total++;
    if (busy !== 1'b0 || empty !== 1'b1)
      $display("FAIL ovf_done: busy=%b empty=%b expected 0 1", busy, empty);
    else passed++;
  endtask

  task automatic test_push_pop();
    do_reset();
    wr_en = 1'b1; wr_data = 8'h11;
    @(negedge clk); wr_data = 8'h22;
    @(negedge clk); wr_data = 8'h33;
    @(negedge clk); wr_data = 8'h44;
    @(negedge clk); wr_data = 8'h55;
    @(negedge clk); wr_en = 1'b0;
    total++;
    if (full !== 1'b1 || count !== 3'd4)
      $display("FAIL pp_fill: full=%b count=%0d expected 1 4", full, count);
    else passed++;
    check_frame(8'h11, 3, 1'b1, 8'h77);
    total++;
    if (full !== 1'b0 || count !== 3'd3)
      $display("FAIL pp_full_drop: full=%b count=%0d expected 0 3", full, count);
    else passed++;
    check_frame(8'h22, 0, 1'b0, 8'h00);
    check_frame(8'h33, 0, 1'b0, 8'h00);
    check_frame(8'h44, 0, 1'b0, 8'h00);
    check_frame(8'h55, 0, 1'b0, 8'h00);
    total++;
    if (busy !== 1'b0 || empty !== 1'b1)
      $display("FAIL pp_no_77: busy=%b empty=%b expected 0 1", busy, empty);
    else passed++;

    do_reset();
    wr_en = 1'b1; wr_data = 8'hA1;
    @(negedge clk); wr_data = 8'hB2;
    @(negedge clk); wr_data = 8'hC3;
    @(negedge clk); wr_en = 1'b0;
    total++;
    if (count !== 3'd2)
      $display("FAIL pp_two: count=%0d expected 2", count);
    else passed++;
    check_frame(8'hA1, 1, 1'b1, 8'hD4);
    total++;
    if (count !== 3'd2 || empty !== 1'b0)
      $display("FAIL pp_accept: count=%0d empty=%b expected 2 0", count, empty);
    else passed++;
    check_frame(8'hB2, 0, 1'b0, 8'h00);
    check_frame(8'hC3, 0, 1'b0, 8'h00);
    check_frame(8'hD4, 0, 1'b0, 8'h00);
    total++;
    if (busy !== 1'b0 || empty !== 1'b1)
      $display("FAIL pp_done: busy=%b empty=%b expected 0 1", busy, empty);
    else passed++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    do_reset();
    wr_en = 1'b1; wr_data = 8'h07;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    check_frame(8'h07, 0, 1'b0, 8'h00);
    total++;
    if (busy !== 1'b0)
      $display("FAIL par_len_07: busy=%b expected 0", busy);
    else passed++;
    wr_en = 1'b1; wr_data = 8'h03;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    check_frame(8'h03, 0, 1'b0, 8'h00);
    total++;
    if (busy !== 1'b0)
      $display("FAIL par_len_03: busy=%b expected 0", busy);
    else passed++;
  endtask
`endif

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
